mem_stage: RTL

Memory-access stage between the ALU and register-file writeback. It takes the ALU result as a load/store address, or as a plain result for non-memory instructions. Loads and stores run as a single-outstanding request/ack transaction on the data bus. The block aligns store data, extracts and sign/zero-extends load data, and presents one writeback beat per instruction. It stalls the upstream pipeline while a bus transaction is in flight.

---
 rtl/mem_stage_if.sv | 30 +++
 rtl/mem_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : Single-outstanding request/ack data bus between the memory
//               stage (master) and the data memory / interconnect (slave).
// Signals     : bus_req/bus_we/bus_addr/bus_wdata/bus_sel  master -> slave
//               bus_ack/bus_err/bus_rdata                  slave  -> master
// Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
        input  bus_ack, bus_err, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
        output bus_ack, bus_err, bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : RV32 memory-access stage. Passes non-memory results straight
//               to writeback, runs loads/stores as one outstanding bus
//               transaction, aligns store data, extracts/extends load data
//               and reports misaligned / illegal / bus-error faults.
// Ports       : clk, nRst                      clock, async active-low reset
//               ex_valid, mem_read, mem_write,
//               funct3, alu_result, store_data,
//               rd_in                          instruction from execute
//               stall                          hold upstream while busy
//               bus (mem_stage_if.master)      data bus
//               wb_valid, wb_we, wb_rd,
//               wb_data, fault                 writeback beat
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage (
    input  wire logic        clk,
    input  wire logic        nRst,
    input  wire logic        ex_valid,
    input  wire logic        mem_read,
    input  wire logic        mem_write,
    input  wire logic [2:0]  funct3,
    input  wire logic [31:0] alu_result,
    input  wire logic [31:0] store_data,
    input  wire logic [4:0]  rd_in,
    output logic             stall,
    mem_stage_if.master      bus,
    output logic             wb_valid,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             fault
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q,   state_d;
    logic [31:0] addr_q,    addr_d;
    logic [1:0]  off_q,     off_d;
    logic [2:0]  f3_q,      f3_d;
    logic [4:0]  rd_q,      rd_d;
    logic        we_q,      we_d;
    logic [3:0]  sel_q,     sel_d;
    logic [31:0] wdata_q,   wdata_d;
    logic        wbv_q,     wbv_d;
    logic        wbwe_q,    wbwe_d;
    logic [4:0]  wbrd_q,    wbrd_d;
    logic [31:0] wbdata_q,  wbdata_d;
    logic        fault_q,   fault_d;

    // ------------------------------------------------------------------
    // Decode of the instruction presented by execute
    // ------------------------------------------------------------------
    logic        w_is_mem;
    logic        w_legal_load;
    logic        w_legal_store;
    logic        w_misaligned;
    logic        w_is_fault;
    logic [3:0]  w_sel_fmt;
    logic [31:0] w_wdata_fmt;

    assign w_is_mem      = mem_read | mem_write;
    assign w_legal_load  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                           (funct3 == 3'b100) || (funct3 == 3'b101);
    assign w_legal_store = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    // funct3[1:0] encodes size: 00 byte, 01 half, 10 word
    assign w_misaligned  = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                           ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
    assign w_is_fault    = w_is_mem &&
                           ((mem_read && mem_write) ||
                            (mem_read  && !w_legal_load) ||
                            (mem_write && !w_legal_store) ||
                            w_misaligned);

    always_comb begin
        w_sel_fmt   = 4'b1111;
        w_wdata_fmt = store_data;
        case (funct3[1:0])
            2'b00: begin
                w_sel_fmt   = 4'b0001 << alu_result[1:0];
                w_wdata_fmt = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_sel_fmt   = 4'b0011 << alu_result[1:0];
                w_wdata_fmt = {2{store_data[15:0]}};
            end
            default: begin
                w_sel_fmt   = 4'b1111;
                w_wdata_fmt = store_data;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data lane extraction and extension
    // ------------------------------------------------------------------
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;

    always_comb begin
        w_byte = bus.bus_rdata[7:0];
        case (off_q)
            2'd0:    w_byte = bus.bus_rdata[7:0];
            2'd1:    w_byte = bus.bus_rdata[15:8];
            2'd2:    w_byte = bus.bus_rdata[23:16];
            default: w_byte = bus.bus_rdata[31:24];
        endcase
    end

    // Halfword loads are only issued at even offsets, so off_q[1] picks the lane
    assign w_half = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];

    always_comb begin
        w_load_val = bus.bus_rdata;
        case (f3_q)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_val = {24'd0, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_val = {16'd0, w_half};
            default: w_load_val = bus.bus_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        off_d    = off_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        wbv_d    = 1'b0;
        wbwe_d   = wbwe_q;
        wbrd_d   = wbrd_q;
        wbdata_d = wbdata_q;
        fault_d  = fault_q;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!w_is_mem) begin
                        wbv_d    = 1'b1;
                        wbwe_d   = 1'b1;
                        wbrd_d   = rd_in;
                        wbdata_d = alu_result;
                        fault_d  = 1'b0;
                    end else if (w_is_fault) begin
                        wbv_d    = 1'b1;
                        wbwe_d   = 1'b0;
                        wbrd_d   = rd_in;
                        wbdata_d = 32'd0;
                        fault_d  = 1'b1;
                    end else begin
                        addr_d  = {alu_result[31:2], 2'b00};
                        off_d   = alu_result[1:0];
                        f3_d    = funct3;
                        rd_d    = rd_in;
                        we_d    = mem_write;
                        sel_d   = w_sel_fmt;
                        wdata_d = w_wdata_fmt;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // Error terminates the transaction and wins over a coincident ack
                if (bus.bus_err) begin
                    wbv_d    = 1'b1;
                    wbwe_d   = 1'b0;
                    wbrd_d   = rd_q;
                    wbdata_d = 32'd0;
                    fault_d  = 1'b1;
                    state_d  = IDLE;
                end else if (bus.bus_ack) begin
                    wbv_d    = 1'b1;
                    wbwe_d   = ~we_q;
                    wbrd_d   = rd_q;
                    wbdata_d = we_q ? 32'd0 : w_load_val;
                    fault_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            off_q    <= 2'd0;
            f3_q     <= 3'd0;
            rd_q     <= 5'd0;
            we_q     <= 1'b0;
            sel_q    <= 4'd0;
            wdata_q  <= 32'd0;
            wbv_q    <= 1'b0;
            wbwe_q   <= 1'b0;
            wbrd_q   <= 5'd0;
            wbdata_q <= 32'd0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            off_q    <= off_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            wdata_q  <= wdata_d;
            wbv_q    <= wbv_d;
            wbwe_q   <= wbwe_d;
            wbrd_q   <= wbrd_d;
            wbdata_q <= wbdata_d;
            fault_q  <= fault_d;
        end
    end

    // Request and stall come straight from the state register so that an
    // asynchronous reset drops them immediately.
    assign stall         = (state_q == BUSY);
    assign bus.bus_req   = (state_q == BUSY);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_sel   = sel_q;

    assign wb_valid = wbv_q;
    assign wb_we    = wbwe_q;
    assign wb_rd    = wbrd_q;
    assign wb_data  = wbdata_q;
    assign fault    = fault_q;

endmodule
`default_nettype wire
